// File: rtl/sm_group_arb.sv
// Group-atomic arbiter: grants a shared sum-every-3 datapath to one requester for three beats and tags each result with its id.
// Optional build macro SM_GROUP_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module sm_group_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned IDQ_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_dval,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ack,
  output logic                     dp_i_dval,
  output logic [DW-1:0]            dp_i,
  input  logic                     dp_o_dval,
  input  logic [DW+1:0]            dp_o,
  output logic                     o_dval,
  output logic [DW+1:0]            o,
  output logic [$clog2(NREQ)-1:0]  o_id,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned QAW = (IDQ_DEPTH > 1) ? $clog2(IDQ_DEPTH) : 1;
  localparam int unsigned QCW = $clog2(IDQ_DEPTH + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   g_q, g_d;
  logic [1:0]       bc_q, bc_d;
`ifndef SM_GROUP_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   rr_q, rr_d;
`endif

  logic [IDW-1:0]   win;
  logic             win_vld;
  logic [DW-1:0]    req_word [NREQ];

  logic [IDW-1:0]   idq_q [IDQ_DEPTH];
  logic [QAW-1:0]   wp_q, rp_q;
  logic [QCW-1:0]   cnt_q;
  logic             push, pop, full, empty;

  function automatic logic [QAW-1:0] ptr_nxt(input logic [QAW-1:0] p);
    return (p == QAW'(IDQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_word[k] = req_data[k*DW +: DW];
    end
  end

  // Winner selection; only consulted while IDLE.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
`ifdef SM_GROUP_ARB_FIXED_PRIO_EN
    for (int unsigned k = NREQ; k > 0; k--) begin
      logic [IDW-1:0] cand;
      cand = IDW'(k - 1);
      if (req_dval[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
`else
    for (int unsigned i = 0; i < NREQ; i++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(rr_q) + i) % NREQ);
      if (!win_vld && req_dval[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
`endif
  end

  assign full  = (cnt_q == QCW'(IDQ_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = dp_o_dval && !empty;
  assign busy  = (state_q == GRANT) | !empty;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    bc_d    = bc_q;
    req_ack = '0;
    push    = 1'b0;
`ifndef SM_GROUP_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld && !full) begin
          push    = 1'b1;
          g_d     = win;
          bc_d    = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_ack[g_q] = req_dval[g_q];
        if (req_dval[g_q]) begin
          bc_d = bc_q + 2'd1;
          if (bc_q == 2'd2) begin
            bc_d    = '0;
            state_d = IDLE;
`ifndef SM_GROUP_ARB_FIXED_PRIO_EN
            rr_d    = (g_q == IDW'(NREQ - 1)) ? '0 : g_q + 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      bc_q      <= '0;
`ifndef SM_GROUP_ARB_FIXED_PRIO_EN
      rr_q      <= '0;
`endif
      dp_i_dval <= 1'b0;
      dp_i      <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      bc_q      <= bc_d;
`ifndef SM_GROUP_ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
      dp_i_dval <= |req_ack;
      if (|req_ack) begin
        dp_i <= req_word[g_q];
      end
    end
  end

  // Id queue and result tagging; a result with no queued id still emits, tagged 0, and flags err.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < IDQ_DEPTH; i++) begin
        idq_q[i] <= '0;
      end
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      o_dval <= 1'b0;
      o      <= '0;
      o_id   <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        idq_q[wp_q] <= win;
        wp_q        <= ptr_nxt(wp_q);
      end
      if (pop) begin
        rp_q <= ptr_nxt(rp_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
      o_dval <= dp_o_dval;
      if (dp_o_dval) begin
        o    <= dp_o;
        o_id <= empty ? '0 : idq_q[rp_q];
        if (empty) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sm_group_arb.md
# sm_group_arb

Group-atomic arbiter that shares one sum-every-3 datapath (`sm_dut`-style: `i_dval`/`i` in, `o_dval`/`o` out, one output per three accepted inputs) between `NREQ` requester streams. It grants the datapath to one requester for exactly three accepted beats, so groups never interleave. It then tags each datapath result with the id of the requester that produced it. It sits between the requester streams and the datapath instance.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DW`, 8, input sample width
- `IDQ_DEPTH`, 4, max groups in flight inside the datapath (power of 2)

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_dval`  in  NREQ  per-requester sample valid
- `req_data`  in  NREQ*DW  per-requester sample; requester k uses bits [k*DW +: DW]
- `req_ack`  out  NREQ  sample from requester k accepted this cycle (combinational)
- `dp_i_dval`  out  1  to datapath `i_dval`
- `dp_i`  out  DW  to datapath `i`
- `dp_o_dval`  in  1  from datapath `o_dval`
- `dp_o`  in  DW+2  from datapath `o`
- `o_dval`  out  1  tagged result valid
- `o`  out  DW+2  group sum
- `o_id`  out  clog2(NREQ)  requester id of the group
- `busy`  out  1  grant active or groups in flight
- `err`  out  1  sticky: datapath result with empty id queue

## Operation
- FSM states: IDLE, GRANT.
- IDLE:
  - If any `req_dval` is set and the id queue is not full, pick a winner `g` per the arbitration policy.
  - Push `g` into the id queue, clear beat count `bc`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `req_ack[g] = req_dval[g]`; all other `req_ack` bits are 0.
  - Each ack increments `bc`. The ack with `bc==2` returns to IDLE and advances the round-robin pointer to `g+1` (mod NREQ).
  - Gaps inside a group are allowed: the grant holds until three beats are accepted, with no timeout.
- Datapath drive, registered: `dp_i_dval <= |req_ack`; `dp_i <= req_data[g]` on ack. `dp_i` holds its value when there is no ack.
- Result path, registered:
  - On `dp_o_dval`: pop the id queue; `o_dval <= 1`, `o <= dp_o`, `o_id <= head`.
  - Otherwise `o_dval <= 0`.
- Id queue:
  - Depth `IDQ_DEPTH`, with wrap-around read/write pointers and an occupancy counter.
  - A push and a pop in the same cycle are both legal; occupancy is unchanged.
  - Push only happens in IDLE and requires not-full, so no overflow is possible.
- A pop with the queue empty sets `err`, which holds until `rst`. In that case `o_dval` still pulses, with `o_id = 0`.
- `busy = (state==GRANT) | (occupancy != 0)`.
- Widths: the sum of three DW-bit samples needs DW+2 bits; `o` is passed through unmodified.

## Timing
- Arbitration: one cycle in IDLE, so there is a one-cycle bubble between consecutive groups. Peak rate is 3 beats per 4 cycles.
- `req_ack` is asserted in the same cycle as the `req_dval` it accepts.
- `dp_i_dval` is asserted one cycle after the corresponding `req_ack`.
- Result: `o_dval` is asserted one cycle after `dp_o_dval`. The datapath latency itself is outside this block.
- Reset values: `req_ack=0`, `dp_i_dval=0`, `dp_i=0`, `o_dval=0`, `o=0`, `o_id=0`, `busy=0`, `err=0`. State IDLE, round-robin pointer 0, id queue empty.
- Reset mid-group drops the partial group. The datapath shares `rst`, so both sides discard it consistently.
- A requester that deasserts `req_dval` while granted stalls the datapath input; other requesters wait.

## Configuration
- `SM_GROUP_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest-index requester with `req_dval` wins; the pointer is unused.
  - Undefined (default): round-robin starting at the pointer; the pointer moves past the winner after each completed group.

## Test plan
- Single requester: req 1 sends 3,4,5 back-to-back → `dp_i_dval` pulses 3 cycles. When the datapath returns 12: `o=12`, `o_id=1`, `err=0`.
- Contention, round-robin: reqs 0 and 2 always valid with constant data 1 and 2 → group order 0,2,0,2. Results `o=3,o_id=0`, `o=6,o_id=2`, alternating; one idle cycle between groups.
- Gappy group: req 3 with `req_dval` pattern 1,0,0,1,0,1 (data 10,20,30) → exactly three acks; grant held throughout; no other requester acked; `o=60`, `o_id=3`.
- Queue full: hold `dp_o_dval=0` with `IDQ_DEPTH=4` → after 4 granted groups, FSM stays IDLE. One `dp_o_dval` frees a slot and the next grant follows within 2 cycles.
- Spurious result: pulse `dp_o_dval` with the queue empty → `err=1` and stays 1 until `rst`; `o_id=0`.
- Reset mid-group: assert `rst` after 2 acks of req 0 → next cycle all outputs are at reset values and `busy=0`. After release, req 0 restarts with a fresh 3-beat group.
- With `SM_GROUP_ARB_FIXED_PRIO_EN`: reqs 0 and 1 always valid → only req 0 is granted.
